// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its two requesters/consumers and the shared ALU.
// The arbiter uses the slave view; requesters, consumers and the ALU use the master view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             p0_req_valid;
    logic             p0_req_ready;
    logic [WIDTH-1:0] p0_a;
    logic [WIDTH-1:0] p0_b;
    logic [3:0]       p0_op;
    logic             p0_rsp_valid;
    logic             p0_rsp_ready;
    logic [WIDTH-1:0] p0_rsp_data;

    logic             p1_req_valid;
    logic             p1_req_ready;
    logic [WIDTH-1:0] p1_a;
    logic [WIDTH-1:0] p1_b;
    logic [3:0]       p1_op;
    logic             p1_rsp_valid;
    logic             p1_rsp_ready;
    logic [WIDTH-1:0] p1_rsp_data;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             flag_z;
    logic             flag_n;
    logic             p1_forced;

    modport slave (
        input  p0_req_valid, p0_a, p0_b, p0_op, p0_rsp_ready,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_req_valid, p1_a, p1_b, p1_op, p1_rsp_ready,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_zero,
        output flag_z, flag_n, p1_forced
    );

    modport master (
        output p0_req_valid, p0_a, p0_b, p0_op, p0_rsp_ready,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
        output p1_req_valid, p1_a, p1_b, p1_op, p1_rsp_ready,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_zero,
        input  flag_z, flag_n, p1_forced
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for the shared execute-stage ALU: port 0 has priority, port 1 is
// protected by a starvation counter. Results land in 1-deep per-port slots; Z/N flags live here.
module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_IDLE = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic             r_p0_vld;
    logic [WIDTH-1:0] r_p0_data;
    logic             r_p1_vld;
    logic [WIDTH-1:0] r_p1_data;
    logic             r_flag_z;
    logic             r_flag_n;
    logic [CNT_W-1:0] r_starve_cnt;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_flag_wr;

    // Grants are held off while reset is asserted so the ALU sees the idle select immediately.
    always_comb begin
        w_elig0   = bus.p0_req_valid & (~r_p0_vld | bus.p0_rsp_ready);
        w_elig1   = bus.p1_req_valid & (~r_p1_vld | bus.p1_rsp_ready);
        w_gnt0    = ~rst & w_elig0 & ((r_starve_cnt < CNT_MAX) | ~w_elig1);
        w_gnt1    = ~rst & w_elig1 & ~w_gnt0;
        w_flag_wr = w_gnt0 & ((bus.p0_op == OP_SUB) | (bus.p0_op == OP_CMP));
    end

    always_comb begin
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_sel = OP_IDLE;
        if (w_gnt0) begin
            bus.alu_a   = bus.p0_a;
            bus.alu_b   = bus.p0_b;
            bus.alu_sel = bus.p0_op;
        end else if (w_gnt1) begin
            bus.alu_a   = bus.p1_a;
            bus.alu_b   = bus.p1_b;
            bus.alu_sel = bus.p1_op;
        end
    end

    assign bus.p0_req_ready = w_gnt0;
    assign bus.p1_req_ready = w_gnt1;
    assign bus.p1_forced    = w_gnt1 & w_elig0 & (r_starve_cnt == CNT_MAX);
    assign bus.p0_rsp_valid = r_p0_vld;
    assign bus.p0_rsp_data  = r_p0_data;
    assign bus.p1_rsp_valid = r_p1_vld;
    assign bus.p1_rsp_data  = r_p1_data;
    assign bus.flag_z       = r_flag_z;
    assign bus.flag_n       = r_flag_n;

    // Result slots: a new grant overwrites the slot even while it drains, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_vld  <= 1'b0;
            r_p0_data <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_data <= '0;
        end else begin
            if (w_gnt0) begin
                r_p0_vld  <= 1'b1;
                r_p0_data <= bus.alu_out;
            end else if (bus.p0_rsp_ready) begin
                r_p0_vld  <= 1'b0;
            end
            if (w_gnt1) begin
                r_p1_vld  <= 1'b1;
                r_p1_data <= bus.alu_out;
            end else if (bus.p1_rsp_ready) begin
                r_p1_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_z     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            if (w_flag_wr) begin
                r_flag_z <= bus.alu_zero;
                r_flag_n <= bus.alu_out[WIDTH-1];
            end
            if (w_elig1 & ~w_gnt1) begin
                if (r_starve_cnt != CNT_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end
endmodule
